// File: rtl/norm_sq_accum.sv
// Streaming sum-of-squares feeding the sqrt block of the FastICA weight-normalisation path.
// Define SQ_PIPE_EN to register the squared term before the accumulator (adds a DRAIN state).

module norm_sq_accum #(
    parameter int DATA_W  = 26,
    parameter int FRAC_W  = 16,
    parameter int VEC_MAX = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sat,
    output logic                     out_err
);
    localparam int CNT_W = $clog2(VEC_MAX);
    localparam int SQ_W  = 2 * DATA_W;
    localparam int ACC_W = SQ_W + CNT_W - FRAC_W;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

`ifdef SQ_PIPE_EN
    localparam state_t AFTER_LAST = DRAIN;
`else
    localparam state_t AFTER_LAST = HOLD;
`endif

    state_t state, state_nxt;

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       term;
    logic [ACC_W-1:0]       add_term;
    logic [CNT_W-1:0]       cnt;
    logic                   err_q;
    logic signed [SQ_W-1:0] sq;
    logic                   accept;
    logic                   at_limit;
    logic                   last_beat;
    logic                   handshake;
    logic                   acc_sat;

    assign accept    = in_valid && in_ready;
    assign at_limit  = (cnt == CNT_W'(VEC_MAX - 1));
    assign last_beat = accept && (in_last || at_limit);
    assign handshake = out_valid && out_ready;

    // The square is never negative, so a logical shift is the truncating Q-format rescale.
    assign sq      = SQ_W'(in_data) * SQ_W'(in_data);
    assign term    = ACC_W'(sq >> FRAC_W);
    assign acc_sat = |acc[ACC_W-1:DATA_W];

`ifdef SQ_PIPE_EN
    logic [ACC_W-1:0] term_q;
    logic             term_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q <= '0;
            term_v <= 1'b0;
        end else begin
            term_v <= accept;
            if (accept) term_q <= term;
        end
    end

    assign add_term = term_v ? term_q : '0;
`else
    assign add_term = accept ? term : '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (handshake) begin
            acc   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            acc <= acc + add_term;
            if (accept) cnt <= cnt + CNT_W'(1);
            if (last_beat && !in_last) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (last_beat)   state_nxt = AFTER_LAST;
                else if (accept) state_nxt = ACCUM;
            end
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sat   = 1'b0;
        out_err   = 1'b0;
        if (rst_n) in_ready = (state == IDLE) || (state == ACCUM);
        if (state == HOLD) begin
            out_valid = 1'b1;
            out_sat   = acc_sat;
            out_err   = err_q;
            out_data  = acc_sat ? '1 : acc[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_norm_sq_accum.sv
// Scoreboard bench for norm_sq_accum; expected results come from a plain integer model.
// Build with SQ_PIPE_EN defined to check the two-cycle latency variant.

module tb_norm_sq_accum;
    localparam int DATA_W = 26;
    localparam int FRAC_W = 16;
`ifdef SQ_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam longint MAX_OUT = (64'sd1 << DATA_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sat;
        logic              err;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_sat;
    logic                     out_err;

    exp_t   sb[$];
    longint vec[$];
    int     vectors = 0;
    int     miscompares = 0;

    norm_sq_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer square, truncate the fraction, sum, then clip.
    task automatic push_model(input bit has_last);
        longint acc;
        exp_t   e;
        acc = 0;
        foreach (vec[i]) acc += (vec[i] * vec[i]) >> FRAC_W;
        e.sat  = (acc > MAX_OUT);
        e.data = e.sat ? '1 : DATA_W'(acc);
        e.err  = !has_last;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexp_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_sat", 64'(out_sat), 64'(e.sat));
                check("out_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic send_beat(input longint v, input bit l);
        int tries;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        in_last  = l;
        tries = 0;
        @(negedge clk);
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_vector(input bit has_last, input bit gaps);
        int n;
        push_model(has_last);
        foreach (vec[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                n = $urandom_range(0, 3);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(vec[i], has_last && (i == vec.size() - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts negedges from the last accepted beat to out_valid; ends on a negedge.
    task automatic wait_result();
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(LAT));
    endtask

    task automatic run_vector(input bit has_last, input bit gaps);
        send_vector(has_last, gaps);
        wait_result();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_sat"}, 64'(out_sat), 64'd0);
        check({tag, "_out_err"}, 64'(out_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four beats of 1.0 -> 4.0
        vec = '{65536, 65536, 65536, 65536};
        run_vector(1'b1, 1'b0);

        // Single-beat vectors: -2.0 -> 4.0, and 2^-16 truncating to zero
        vec = '{-131072};
        run_vector(1'b1, 1'b0);
        vec = '{1};
        run_vector(1'b1, 1'b0);

        // Most negative input squares to 2^50 and saturates the output
        vec = '{-33554432};
        run_vector(1'b1, 1'b0);

        // 64 beats of 100.0 with no in_last: forced end, error and saturation
        vec.delete();
        repeat (64) vec.push_back(6553600);
        run_vector(1'b0, 1'b0);

        // in_last on exactly the 64th beat is a normal end: no error
        vec.delete();
        repeat (64) vec.push_back(256);
        run_vector(1'b1, 1'b0);

        // Downstream stall while a new beat waits on the input
        out_ready = 1'b0;
        vec = '{65536, 65536, 65536};
        send_vector(1'b1, 1'b0);
        wait_result();
        vec = '{131072};
        push_model(1'b1);
        in_valid = 1'b1;
        in_data  = DATA_W'(131072);
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_data", 64'(out_data), 64'd196608);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hs_out_valid", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result();
        @(posedge clk);
        #1;

        // Three beats of 0.5 with random idle gaps, then gap-free: both 0.75
        vec = '{32768, 32768, 32768};
        run_vector(1'b1, 1'b1);
        run_vector(1'b1, 1'b0);

        // Reset mid-vector must leave no residue
        send_beat(65536, 1'b0);
        send_beat(65536, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec = '{65536, 65536};
        run_vector(1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
